// File: rtl/level_sequencer.sv
// level_sequencer: game-progression controller. Tracks level, lives and filled
// homes, sequences IDLE/PLAY/DEATH/CLEAR/OVER/WIN, and issues one-cycle
// level_load / respawn strobes to the movers and the frog controller.
module level_sequencer #(
  parameter int unsigned NUM_LEVELS   = 3,
  parameter int unsigned START_LIVES  = 3,
  parameter int unsigned HOMES        = 5,
  parameter int unsigned PAUSE_FRAMES = 60
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       frog_home,
  input  logic       frog_dead,
  output logic [7:0] Level,
  output logic [2:0] Lives,
  output logic [2:0] HomesFilled,
  output logic [2:0] State,
  output logic       play_en,
  output logic       respawn,
  output logic       level_load,
  output logic       game_over
);

  localparam int unsigned LEVEL_W = 8;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned PAUSE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_DEATH = 3'd2,
    S_CLEAR = 3'd3,
    S_OVER  = 3'd4,
    S_WIN   = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0]   lives_q, lives_d;
  logic [CNT_W-1:0]   homes_q, homes_d;
  logic [PAUSE_W-1:0] pause_q, pause_d;
  logic               start_q;
  logic               respawn_q, respawn_d;
  logic               level_load_q, level_load_d;
  logic               play_en_q, game_over_q;
  logic               start_edge;
  logic [CNT_W-1:0]   homes_inc;

  assign start_edge = start & ~start_q;
  assign homes_inc  = homes_q + CNT_W'(1);

  // Next-state, counters and strobes; strobes default low every cycle.
  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    lives_d      = lives_q;
    homes_d      = homes_q;
    pause_d      = pause_q;
    respawn_d    = 1'b0;
    level_load_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d      = S_PLAY;
          level_d      = LEVEL_W'(1);
          lives_d      = CNT_W'(START_LIVES);
          homes_d      = '0;
          level_load_d = 1'b1;
          respawn_d    = 1'b1;
        end
      end
      S_PLAY: begin
        // A death wins over a same-cycle home landing.
        if (frog_dead) begin
          if (lives_q == CNT_W'(1)) begin
            lives_d = '0;
            state_d = S_OVER;
          end else begin
            lives_d = lives_q - CNT_W'(1);
            pause_d = PAUSE_W'(PAUSE_FRAMES);
            state_d = S_DEATH;
          end
        end else if (frog_home) begin
          homes_d = homes_inc;
          if (homes_inc == CNT_W'(HOMES)) begin
            pause_d = PAUSE_W'(PAUSE_FRAMES);
            state_d = S_CLEAR;
          end else begin
            respawn_d = 1'b1;
          end
        end
      end
      S_DEATH, S_CLEAR: begin
        if (frame_tick) begin
          pause_d = pause_q - PAUSE_W'(1);
          if (pause_q == PAUSE_W'(1)) begin
            if (state_q == S_DEATH) begin
              state_d   = S_PLAY;
              respawn_d = 1'b1;
            end else if (level_q == LEVEL_W'(NUM_LEVELS)) begin
              state_d = S_WIN;
            end else begin
              state_d      = S_PLAY;
              level_d      = level_q + LEVEL_W'(1);
              homes_d      = '0;
              lives_d      = (lives_q == CNT_W'(7)) ? lives_q : lives_q + CNT_W'(1);
              level_load_d = 1'b1;
              respawn_d    = 1'b1;
            end
          end
        end
      end
      S_OVER, S_WIN: begin
        if (start_edge) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q      <= S_IDLE;
      level_q      <= LEVEL_W'(1);
      lives_q      <= CNT_W'(START_LIVES);
      homes_q      <= '0;
      pause_q      <= '0;
      start_q      <= 1'b0;
      respawn_q    <= 1'b0;
      level_load_q <= 1'b0;
      play_en_q    <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      lives_q      <= lives_d;
      homes_q      <= homes_d;
      pause_q      <= pause_d;
      start_q      <= start;
      respawn_q    <= respawn_d;
      level_load_q <= level_load_d;
      play_en_q    <= (state_d == S_PLAY);
      game_over_q  <= (state_d == S_OVER) || (state_d == S_WIN);
    end
  end

  assign Level       = level_q;
  assign Lives       = lives_q;
  assign HomesFilled = homes_q;
  assign State       = state_q;
  assign play_en     = play_en_q;
  assign respawn     = respawn_q;
  assign level_load  = level_load_q;
  assign game_over   = game_over_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Scoreboard bench for level_sequencer: the driver applies stimulus each cycle,
// advances a game-rules model and queues the expected output snapshot; a
// separate monitor pops and compares after every active clock edge.
module tb_level_sequencer;

  localparam int NL = 3;
  localparam int SL = 3;
  localparam int NH = 5;
  localparam int PF = 60;

  logic       Clk = 1'b1;
  logic       Reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       frog_home = 1'b0;
  logic       frog_dead = 1'b0;
  logic [7:0] Level;
  logic [2:0] Lives, HomesFilled, State;
  logic       play_en, respawn, level_load, game_over;

  level_sequencer dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .start(start),
    .frog_home(frog_home), .frog_dead(frog_dead), .Level(Level), .Lives(Lives),
    .HomesFilled(HomesFilled), .State(State), .play_en(play_en),
    .respawn(respawn), .level_load(level_load), .game_over(game_over)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int st, lvl, lives, homes;
    bit play, resp, load, over;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   done = 0;

  // Game-rules model: named phase plus plain integer bookkeeping.
  int  phase, lvl, lives, homes, ticks_left;
  bit  prev_start, s_resp, s_load;

  task automatic model_step(input bit rn, ft, st, fh, fd);
    bit pressed;
    s_resp = 0;
    s_load = 0;
    if (!rn) begin
      phase = 0; lvl = 1; lives = SL; homes = 0; ticks_left = 0; prev_start = 0;
      return;
    end
    pressed = st && !prev_start;
    prev_start = st;
    if (phase == 0) begin
      if (pressed) begin
        phase = 1; lvl = 1; lives = SL; homes = 0; s_load = 1; s_resp = 1;
      end
    end else if (phase == 1) begin
      if (fd) begin
        lives = lives - 1;
        if (lives == 0) phase = 4;
        else begin phase = 2; ticks_left = PF; end
      end else if (fh) begin
        homes = homes + 1;
        if (homes == NH) begin phase = 3; ticks_left = PF; end
        else s_resp = 1;
      end
    end else if (phase == 2 || phase == 3) begin
      if (ft) begin
        ticks_left = ticks_left - 1;
        if (ticks_left == 0) begin
          if (phase == 2) begin phase = 1; s_resp = 1; end
          else if (lvl == NL) phase = 5;
          else begin
            lvl = lvl + 1; homes = 0;
            if (lives < 7) lives = lives + 1;
            s_load = 1; s_resp = 1; phase = 1;
          end
        end
      end
    end else begin
      if (pressed) phase = 0;
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic cyc(input bit rn, ft, st, fh, fd);
    exp_t e;
    @(negedge Clk);
    Reset_n = rn; frame_tick = ft; start = st; frog_home = fh; frog_dead = fd;
    model_step(rn, ft, st, fh, fd);
    e.st = phase; e.lvl = lvl; e.lives = lives; e.homes = homes;
    e.play = (phase == 1); e.resp = s_resp; e.load = s_load;
    e.over = (phase == 4 || phase == 5);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin cyc(1, 1, 0, 0, 0); cyc(1, 0, 0, 0, 0); end
  endtask

  task automatic press_start();
    cyc(1, 0, 1, 0, 0); cyc(1, 0, 1, 0, 0); cyc(1, 0, 0, 0, 0);
  endtask

  task automatic clear_level();
    for (int i = 0; i < NH; i++) begin cyc(1, 0, 0, 1, 0); cyc(1, 0, 0, 0, 0); end
    ticks(PF);
  endtask

  // Monitor: compare DUT outputs against the queued expectation every cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (done) break;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty: DUT output with no expectation at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (State !== 3'(e.st) || Level !== 8'(e.lvl) || Lives !== 3'(e.lives) ||
            HomesFilled !== 3'(e.homes) || play_en !== e.play || respawn !== e.resp ||
            level_load !== e.load || game_over !== e.over) begin
          failures++;
          if (failures <= 30)
            $display("FAIL outputs @%0t: got st=%0d lvl=%0d lives=%0d homes=%0d play=%0b resp=%0b load=%0b over=%0b want st=%0d lvl=%0d lives=%0d homes=%0d play=%0b resp=%0b load=%0b over=%0b",
                     $time, State, Level, Lives, HomesFilled, play_en, respawn, level_load, game_over,
                     e.st, e.lvl, e.lives, e.homes, e.play, e.resp, e.load, e.over);
        end
      end
    end
  end

  // Stimulus: directed game scenarios, then randomized play.
  initial begin
    cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    idle(3);
    press_start();                         // held start gives one edge
    for (int i = 0; i < NH - 1; i++) begin cyc(1, 0, 0, 1, 0); cyc(1, 0, 0, 0, 0); end
    cyc(1, 1, 0, 1, 0);                    // fifth home; same-cycle tick not counted
    ticks(PF);                             // level 2, lives 4
    idle(2);
    cyc(1, 0, 0, 1, 1);                    // death beats home
    cyc(1, 1, 0, 0, 1);                    // events ignored during pause
    ticks(PF - 1);
    idle(2);
    clear_level();                         // level 3
    clear_level();                         // WIN
    for (int i = 0; i < 6; i++) cyc(1, 1, 0, i[0], ~i[0]);
    press_start();                         // to IDLE
    press_start();                         // new game
    for (int d = 0; d < SL; d++) begin
      cyc(1, 0, 0, 0, 1);
      if (d < SL - 1) ticks(PF);
    end
    for (int i = 0; i < 6; i++) cyc(1, 1, 0, i[0], ~i[0]);
    press_start();
    press_start();
    for (int i = 0; i < NH; i++) begin cyc(1, 0, 0, 1, 0); cyc(1, 0, 0, 0, 0); end
    ticks(30);
    cyc(0, 1, 0, 0, 0);                    // reset mid-CLEAR
    idle(3);
    press_start();
    for (int i = 0; i < 6000; i++) begin
      cyc(($urandom_range(0, 799) != 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 39) < 3), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 59) == 0));
    end
    idle(2);
    @(posedge Clk);
    #2;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/level_sequencer.md
# level_sequencer

Game-progression controller that drives the 8-bit level number consumed by the level configuration table, which sets lane direction, speed, count and offsets. Tracks lives and filled home slots. Sequences the game through attract, play, death pause, level-clear pause and end states. Issues one-cycle load and respawn strobes to the object movers and the frog controller. Sits between the keyboard/collision logic and the level configuration table.

## Interface
- NUM_LEVELS, 3: last playable level; Level runs 1..NUM_LEVELS.
- START_LIVES, 3: lives loaded at reset and on a new game; range 1..7.
- HOMES, 5: home slots to fill to clear a level; range 1..7.
- PAUSE_FRAMES, 60: frame ticks spent in the DEATH and CLEAR pauses; range 1..255.
- Clk  in  1  system clock; the only clock.
- Reset_n  in  1  synchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- start  in  1  start key, level-sensitive; only its rising edge is used.
- frog_home  in  1  one-cycle pulse when the frog lands in an empty home.
- frog_dead  in  1  one-cycle pulse on collision, drowning or timeout.
- Level  out  8  current level number, fed to the configuration table.
- Lives  out  3  remaining lives.
- HomesFilled  out  3  homes filled on the current level.
- State  out  3  encoded as IDLE=0, PLAY=1, DEATH=2, CLEAR=3, OVER=4, WIN=5.
- play_en  out  1  high only in PLAY; gates object motion and frog input.
- respawn  out  1  one-cycle strobe; frog returns to the start cell.
- level_load  out  1  one-cycle strobe; movers reload lane offsets from the table.
- game_over  out  1  high in OVER or WIN.

## Operation
- Rising-edge detect on start: start_edge = start & ~start_q. start_q is a register, cleared by reset.
- All outputs are registered. Strobes default to 0 every cycle unless set below.
- Reset values: State=IDLE, Level=8'h01, Lives=START_LIVES, HomesFilled=0, pause counter=0, all strobes=0, play_en=0, game_over=0.
- IDLE, on start_edge:
  - go to PLAY;
  - set Level=1, Lives=START_LIVES, HomesFilled=0;
  - pulse level_load and respawn.
- PLAY, frog_dead (takes priority over a same-cycle frog_home; that frog_home is dropped):
  - if Lives==1: Lives=0, go to OVER;
  - else: Lives decrements, pause counter=PAUSE_FRAMES, go to DEATH.
- PLAY, frog_home only:
  - HomesFilled increments;
  - if the new value equals HOMES: pause counter=PAUSE_FRAMES, go to CLEAR;
  - else: pulse respawn and stay in PLAY.
- DEATH:
  - frog_home and frog_dead are ignored;
  - on each frame_tick the counter decrements;
  - on the tick where the counter is 1: go to PLAY, pulse respawn.
- CLEAR, same counting. On expiry:
  - if Level==NUM_LEVELS: go to WIN.
  - else: Level increments, HomesFilled=0, Lives increments (saturating at 7), pulse level_load and respawn, go to PLAY.
- OVER / WIN:
  - all event inputs are ignored;
  - start_edge goes to IDLE. No strobes are issued; the next start_edge begins a new game.
- frame_tick has no effect in IDLE, PLAY, OVER or WIN.
- Level never exceeds NUM_LEVELS and never reads 0.

## Timing
- Input event at cycle N: State, Lives, HomesFilled and strobes are updated at N+1.
- Each strobe is high for exactly one cycle.
- play_en and game_over are decoded from the registered state and track State with no additional cycle of delay.
- Pause length is exactly PAUSE_FRAMES frame_tick pulses, counted after entry. A frame_tick in the same cycle as the entering event is not counted.
- level_load and respawn assert in the same cycle as the new Level value. The table is combinational, so its outputs are valid in that same cycle.
- Reset_n low overrides every transition, including mid-pause and mid-strobe. Strobes read 0 on the cycle after reset is sampled.
- start held high continuously produces only one start_edge.

## Test plan
- Reset, then start pulse → next cycle: State=1, Level=1, Lives=3, level_load=1 and respawn=1 for one cycle, play_en=1.
- In PLAY, 4 frog_home pulses → HomesFilled=4 with 4 respawn pulses. Fifth pulse → State=3. After exactly 60 frame_ticks → Level=2, Lives=4, HomesFilled=0, level_load=1 for one cycle.
- frog_dead and frog_home in the same cycle with Lives=3 → Lives=2, HomesFilled unchanged, State=2. After 60 ticks → State=1, respawn pulse.
- Three deaths from Lives=3 → Lives=0, State=4, game_over=1. Ticks and events produce no change. start edge → IDLE; second start edge → Level=1, Lives=3.
- Clear level 3 (NUM_LEVELS) → State=5, Level stays 3, no level_load.
- Assert Reset_n low for one cycle at frame 30 of a CLEAR pause → every output returns to its reset value on the next cycle, with no strobes.
